gate_sweep_checker: RTL and testbench
=====================================

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; it drives the two gate inputs and consumes the 7-bit gate result bus.
REQ-002 Parameter: SETTLE, default 2, number of clock cycles each input vector is held before the result bus is sampled; legal range 1..15.
REQ-003 Port: i_clk  input  1  rising-edge clock for all state.
REQ-004 Port: i_rst  input  1  synchronous active-high reset.
REQ-005 Port: i_start  input  1  starts one exhaustive sweep; sampled only in IDLE.
REQ-006 Port: i_y  input  7  result bus from the gate stage: [0]=NOT a, [1]=AND, [2]=OR, [3]=NAND, [4]=NOR, [5]=XOR, [6]=XNOR.
REQ-007 Port: o_a  output  1  gate input a, registered.
REQ-008 Port: o_b  output  1  gate input b, registered.
REQ-009 Port: o_busy  output  1  high while a sweep is in progress.
REQ-010 Port: o_done  output  1  one-cycle pulse at sweep end.
REQ-011 Port: o_pass  output  1  1 when the last completed sweep had zero mismatches.
REQ-012 Port: o_err_cnt  output  3  number of failing vectors in the last sweep, 0..4.
REQ-013 Port: o_fail_mask  output  4  bit k set when vector k failed.
REQ-014 Port: o_fail_bits  output  7  OR of all per-vector mismatch bits (expected XOR i_y).

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and DONE; the vector index v is 2 bits, with o_a=v[1] and o_b=v[0], and the sweep order is 00, 01, 10, 11.
REQ-016 In IDLE, when i_start=1 at edge T, the block SHALL set v=0, clear o_err_cnt/o_fail_mask/o_fail_bits/o_pass, clear the settle counter, set o_busy=1, and enter WAIT; o_a=0 and o_b=0 are driven from T.
REQ-017 In WAIT, the settle counter SHALL increment every cycle; the SETTLE-th WAIT edge is the check edge, at which i_y is sampled and compared.
REQ-018 Expected value per vector: NOT a, a&b, a|b, ~(a&b), ~(a|b), a^b, ~(a^b); mismatch vector m = expected XOR i_y.
REQ-019 At the check edge, if m!=0: o_err_cnt+1, o_fail_mask[v]=1, o_fail_bits |= m.
REQ-020 At the check edge with v<3: v increments, o_a/o_b update at the same edge, the counter clears and the FSM stays in WAIT; each vector is therefore held for exactly SETTLE cycles.
REQ-021 At the check edge with v=3: o_a=o_b=0, o_busy=0, the FSM enters DONE, o_done=1 for exactly that one cycle, and o_pass=(final o_err_cnt==0).
REQ-022 From DONE, the FSM SHALL return to IDLE unconditionally on the next edge; i_start in DONE is ignored.
REQ-023 Latency: with start sampled at edge 0, o_done SHALL be high in the cycle following edge 4*SETTLE, i.e. 4*SETTLE+1 cycles after start; with SETTLE=2, done follows edge 8.
REQ-024 i_start while o_busy=1 SHALL be ignored, with no restart or timing change.
REQ-025 Result outputs SHALL hold their values from DONE until the next accepted start.
REQ-026 The first check edge falls SETTLE cycles after o_a/o_b change, so i_y is never sampled in the same cycle the inputs change.

Reset
REQ-027 On i_rst=1 at an edge, the block SHALL go to IDLE with o_a=0, o_b=0, o_busy=0, o_done=0, o_pass=0, o_err_cnt=0, o_fail_mask=0, o_fail_bits=0, v=0 and counter=0.
REQ-028 Reset mid-sweep SHALL abort the sweep with no o_done pulse; reset SHALL take priority over i_start in the same cycle.

Verification
REQ-029 Correct gate stage, SETTLE=2, start at edge 0 -> o_a/o_b sequence 00,01,10,11 for 2 cycles each; o_done in the cycle after edge 8; o_pass=1, o_err_cnt=0, o_fail_mask=0000, o_fail_bits=0x00.
REQ-030 i_y[5] stuck at 0 -> o_err_cnt=2, o_fail_mask=0110, o_fail_bits=0x20, o_pass=0.
REQ-031 i_y forced to 0x00 -> per-vector expected values 0x59, 0x2D, 0x2C, 0x46; o_err_cnt=4, o_fail_mask=1111, o_fail_bits=0x7F, o_pass=0.
REQ-032 Reset at edge 4 of a sweep -> all outputs 0 after that edge, no o_done; a later start gives the REQ-029 result.
REQ-033 i_start held high for an entire sweep -> start accepted only at edge 0, done timing unchanged; a new sweep is accepted at the first IDLE edge after DONE, with results cleared at that edge.
REQ-034 SETTLE=1 with a correct gate stage -> o_done in the cycle after edge 4, o_pass=1.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// Exhaustive two-input gate checker: drives all four (a,b) vectors, holds each for SETTLE
// cycles, compares the 7-bit gate result bus against the ideal truth table and reports the result.
module gate_sweep_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [6:0] i_y,
    output logic       o_a,
    output logic       o_b,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [2:0] o_err_cnt,
    output logic [3:0] o_fail_mask,
    output logic [6:0] o_fail_bits
);

    // Counter value on the last settle cycle of a vector, which is the check edge.
    localparam logic [3:0] LastCnt = 4'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;

    state_t     r_state;
    logic [1:0] r_v;
    logic [3:0] r_cnt;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err_cnt;
    logic [3:0] r_fail_mask;
    logic [6:0] r_fail_bits;

    logic       w_va;
    logic       w_vb;
    logic [6:0] w_exp;
    logic [6:0] w_mism;
    logic [2:0] w_err_next;

    assign w_va       = r_v[1];
    assign w_vb       = r_v[0];
    assign w_exp      = {~(w_va ^ w_vb), w_va ^ w_vb, ~(w_va | w_vb), ~(w_va & w_vb),
                         w_va | w_vb, w_va & w_vb, ~w_va};
    assign w_mism     = w_exp ^ i_y;
    assign w_err_next = r_err_cnt + {2'b00, |w_mism};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_v         <= 2'd0;
            r_cnt       <= 4'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= 3'd0;
            r_fail_mask <= 4'd0;
            r_fail_bits <= 7'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_v         <= 2'd0;
                        r_cnt       <= 4'd0;
                        r_a         <= 1'b0;
                        r_b         <= 1'b0;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_err_cnt   <= 3'd0;
                        r_fail_mask <= 4'd0;
                        r_fail_bits <= 7'd0;
                        r_state     <= StWait;
                    end
                end
                StWait: begin
                    if (r_cnt == LastCnt) begin
                        if (|w_mism) begin
                            r_err_cnt        <= w_err_next;
                            r_fail_mask[r_v] <= 1'b1;
                            r_fail_bits      <= r_fail_bits | w_mism;
                        end
                        r_cnt <= 4'd0;
                        if (r_v != 2'd3) begin
                            // Next vector goes out on the same edge as the check.
                            r_v          <= r_v + 2'd1;
                            {r_a, r_b}   <= r_v + 2'd1;
                        end else begin
                            r_v     <= 2'd0;
                            r_a     <= 1'b0;
                            r_b     <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 3'd0);
                            r_state <= StDone;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_a         = r_a;
    assign o_b         = r_b;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_cnt   = r_err_cnt;
    assign o_fail_mask = r_fail_mask;
    assign o_fail_bits = r_fail_bits;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (SETTLE=2 and SETTLE=1) driven by a modelled
// gate stage with selectable faults; results are compared against a truth-table reference.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start2, start1;
    logic [6:0] y2, y1;
    logic       a2, b2, busy2, done2, pass2;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err2, err1;
    logic [3:0] mask2, mask1;
    logic [6:0] bits2, bits1;

    int         fault_mode;
    logic [6:0] corrupt [4];
    logic       sel;

    int checks   = 0;
    int failures = 0;

    gate_sweep_checker #(.SETTLE(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_y(y2),
        .o_a(a2), .o_b(b2), .o_busy(busy2), .o_done(done2), .o_pass(pass2),
        .o_err_cnt(err2), .o_fail_mask(mask2), .o_fail_bits(bits2)
    );

    gate_sweep_checker #(.SETTLE(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_y(y1),
        .o_a(a1), .o_b(b1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
        .o_err_cnt(err1), .o_fail_mask(mask1), .o_fail_bits(bits1)
    );

    // Ideal gate stage truth table, bit order [0]=NOT a ... [6]=XNOR.
    function automatic logic [6:0] gate_exp(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
    endfunction

    // Modelled gate stage as seen by the checker under the current fault mode.
    function automatic logic [6:0] gate_model(input logic a, input logic b, input int mode,
                                              input logic [6:0] flip);
        case (mode)
            1:       return gate_exp(a, b) & 7'h5F;
            2:       return 7'h00;
            3:       return gate_exp(a, b) ^ flip;
            default: return gate_exp(a, b);
        endcase
    endfunction

    assign y2 = gate_model(a2, b2, fault_mode, corrupt[{a2, b2}]);
    assign y1 = gate_model(a1, b1, fault_mode, corrupt[{a1, b1}]);

    logic       m_a, m_b, m_busy, m_done, m_pass;
    logic [2:0] m_err;
    logic [3:0] m_mask;
    logic [6:0] m_bits;

    always_comb begin
        m_a = sel ? a1 : a2;
        m_b = sel ? b1 : b2;
        m_busy = sel ? busy1 : busy2;
        m_done = sel ? done1 : done2;
        m_pass = sel ? pass1 : pass2;
        m_err = sel ? err1 : err2;
        m_mask = sel ? mask1 : mask2;
        m_bits = sel ? bits1 : bits2;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start2 = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag, input logic [2:0] e_err,
                                 input logic [3:0] e_mask, input logic [6:0] e_bits,
                                 input logic e_pass);
        check({tag, " err_cnt"}, 32'(m_err), 32'(e_err));
        check({tag, " fail_mask"}, 32'(m_mask), 32'(e_mask));
        check({tag, " fail_bits"}, 32'(m_bits), 32'(e_bits));
        check({tag, " pass"}, 32'(m_pass), 32'(e_pass));
    endtask

    // Runs one sweep starting at the next edge (edge 0) and checks every cycle through edge 4S+1.
    task automatic run_sweep(input int s, input logic hold, input logic [2:0] e_err,
                             input logic [3:0] e_mask, input logic [6:0] e_bits,
                             input logic e_pass);
        set_start(1'b1);
        tick();
        if (!hold) set_start(1'b0);
        check("start busy", 32'(m_busy), 32'd1);
        check("start ab", 32'({m_a, m_b}), 32'd0);
        check("start cleared", 32'({m_err, m_mask, m_bits, m_pass}), 32'd0);
        for (int k = 1; k <= 4 * s; k++) begin
            tick();
            if (k < 4 * s) begin
                check("vector ab", 32'({m_a, m_b}), 32'(k / s));
                check("busy during sweep", 32'({m_busy, m_done}), 32'b10);
            end else begin
                check("done pulse", 32'({m_busy, m_done}), 32'b01);
                check("end ab", 32'({m_a, m_b}), 32'd0);
                check_results("done", e_err, e_mask, e_bits, e_pass);
            end
        end
        tick();
        check("done one cycle", 32'({m_busy, m_done}), 32'b00);
        check_results("held", e_err, e_mask, e_bits, e_pass);
    endtask

    task automatic model_sweep(output logic [2:0] e_err, output logic [3:0] e_mask,
                               output logic [6:0] e_bits, output logic e_pass);
        logic [6:0] m;
        e_err = 0; e_mask = 0; e_bits = 0;
        for (int v = 0; v < 4; v++) begin
            m = gate_exp(v[1], v[0]) ^ gate_model(v[1], v[0], fault_mode, corrupt[v]);
            if (m != 0) begin
                e_err++;
                e_mask[v] = 1'b1;
                e_bits |= m;
            end
        end
        e_pass = (e_err == 0);
    endtask

    typedef struct {
        int         mode;
        logic [2:0] err;
        logic [3:0] mask;
        logic [6:0] bits;
        logic       pass;
    } vec_t;

    vec_t tbl [3];

    initial begin
        logic [2:0] e_err;
        logic [3:0] e_mask;
        logic [6:0] e_bits;
        logic       e_pass;

        tbl[0] = '{mode: 0, err: 3'd0, mask: 4'b0000, bits: 7'h00, pass: 1'b1};
        tbl[1] = '{mode: 1, err: 3'd2, mask: 4'b0110, bits: 7'h20, pass: 1'b0};
        tbl[2] = '{mode: 2, err: 3'd4, mask: 4'b1111, bits: 7'h7F, pass: 1'b0};

        fault_mode = 0;
        for (int i = 0; i < 4; i++) corrupt[i] = 7'h00;
        sel = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("reset dut2", 32'({a2, b2, busy2, done2, pass2, err2, mask2, bits2}), 32'd0);
        check("reset dut1", 32'({a1, b1, busy1, done1, pass1, err1, mask1, bits1}), 32'd0);
        rst = 1'b0;
        tick();

        // Reference truth-table sweeps with SETTLE=2 and SETTLE=1.
        for (int i = 0; i < 3; i++) begin
            fault_mode = tbl[i].mode;
            sel = 1'b0;
            run_sweep(2, 1'b0, tbl[i].err, tbl[i].mask, tbl[i].bits, tbl[i].pass);
            sel = 1'b1;
            run_sweep(1, 1'b0, tbl[i].err, tbl[i].mask, tbl[i].bits, tbl[i].pass);
        end

        // Reset at edge 4 aborts the sweep with no done pulse.
        sel = 1'b0;
        fault_mode = 0;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        for (int k = 1; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset abort outputs", 32'({a2, b2, busy2, done2, pass2, err2, mask2, bits2}),
              32'd0);
        begin
            int seen = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (done2 || busy2) seen++;
            end
            check("no done after abort", 32'(seen), 32'd0);
        end
        run_sweep(2, 1'b0, 3'd0, 4'b0000, 7'h00, 1'b1);

        // Reset wins over start in the same cycle.
        rst = 1'b1;
        start2 = 1'b1;
        tick();
        rst = 1'b0;
        start2 = 1'b0;
        check("reset over start", 32'({busy2, a2, b2}), 32'd0);
        tick();
        check("reset over start later", 32'(busy2), 32'd0);

        // Start held high: failing sweep, then a new sweep accepted right after DONE clears results.
        fault_mode = 2;
        run_sweep(2, 1'b1, 3'd4, 4'b1111, 7'h7F, 1'b0);
        fault_mode = 0;
        tick();
        check("restart busy", 32'(busy2), 32'd1);
        check_results("restart cleared", 3'd0, 4'b0000, 7'h00, 1'b0);
        start2 = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        check("restart done", 32'({done2, pass2}), 32'b11);
        tick();

        // Random per-vector corruption against the reference model.
        fault_mode = 3;
        for (int it = 0; it < 12; it++) begin
            for (int v = 0; v < 4; v++)
                corrupt[v] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'h00;
            sel = 1'($urandom_range(0, 1));
            model_sweep(e_err, e_mask, e_bits, e_pass);
            run_sweep(sel ? 1 : 2, 1'b0, e_err, e_mask, e_bits, e_pass);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
